pc_gen: RTL

- Parametrised program-counter generator for the MIPS fetch stage; successor to the plain enable/reset PC register.
- Selects the next PC by fixed priority from exception, exception-return, branch, jump/call, return and sequential sources.
- Contains a circular return-address stack (RAS) that supplies return targets on ret_req.
- Sits between the control/hazard unit and instruction memory; pc drives IM address directly.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/ras_stack.sv | 54 +++++
 rtl/pc_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select encoding for the fetch-stage PC generator.
package pc_pkg;

   localparam int unsigned PC_W_DEF      = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
   localparam int unsigned STEP_DEF      = 4;
   localparam int unsigned RAS_DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      SEL_RST,
      SEL_EXC,
      SEL_ERET,
      SEL_HOLD,
      SEL_BR,
      SEL_JMP,
      SEL_RET,
      SEL_SEQ
   } sel_e;

   // Only eret/branch/jump/ret targets come from outside and may be misaligned.
   function automatic logic is_ext_target(input sel_e sel);
      return (sel == SEL_ERET) || (sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_RET);
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] tos_q, tos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign top   = mem_q[tos_q];

   // Push wins over pop; a pop on an empty stack is ignored.
   always_comb begin
      tos_d = tos_q;
      cnt_d = cnt_q;
      if (push) begin
         tos_d = tos_q + PTR_W'(1);
         if (!full) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !empty) begin
         tos_d = tos_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tos_q <= '0;
         cnt_q <= '0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[tos_d] <= push_data;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: fixed-priority next-PC mux, PC register and RAS.
// Optional alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = PC_W_DEF,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
   parameter int unsigned      STEP      = STEP_DEF,
   parameter int unsigned      RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc_in,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp_req,
   input  logic             call,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             ret_req,
   input  logic [WIDTH-1:0] ret_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
`ifdef PC_ALIGN_CHECK_EN
   output logic             misalign,
`endif
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_hit
);

   logic [WIDTH-1:0] pc_q, pc_d, pc_raw;
   logic             ras_hit_q, ras_hit_d;
   logic [WIDTH-1:0] link_addr;
   logic [WIDTH-1:0] ras_top;
   logic             ras_push, ras_pop;
   sel_e             sel;

`ifdef PC_ALIGN_CHECK_EN
   logic             misalign_q, misalign_d;
`endif

   assign pc_plus   = pc_q + WIDTH'(STEP);
   assign link_addr = pc_q + WIDTH'(2 * STEP);
   assign pc        = pc_q;
   assign ras_hit   = ras_hit_q;

   // Fixed-priority source select; a pending misalign trap outranks everything below eret.
   always_comb begin
      sel = SEL_SEQ;
      if (rst)                 sel = SEL_RST;
      else if (exc_req)        sel = SEL_EXC;
      else if (eret_req)       sel = SEL_ERET;
`ifdef PC_ALIGN_CHECK_EN
      else if (misalign_q)     sel = SEL_EXC;
`endif
      else if (!en)            sel = SEL_HOLD;
      else if (br_taken)       sel = SEL_BR;
      else if (jmp_req)        sel = SEL_JMP;
      else if (ret_req)        sel = SEL_RET;
   end

   assign ras_push = (sel == SEL_JMP) && call;
   assign ras_pop  = (sel == SEL_RET);

   always_comb begin
      pc_raw    = pc_plus;
      ras_hit_d = 1'b0;
      unique case (sel)
         SEL_RST:  pc_raw = RESET_VEC;
         SEL_EXC:  pc_raw = EXC_VEC;
         SEL_ERET: pc_raw = epc_in;
         SEL_HOLD: pc_raw = pc_q;
         SEL_BR:   pc_raw = br_target;
         SEL_JMP:  pc_raw = jmp_target;
         SEL_RET: begin
            pc_raw    = ras_empty ? ret_target : ras_top;
            ras_hit_d = !ras_empty && (ras_top == ret_target);
         end
         SEL_SEQ:  pc_raw = pc_plus;
         default:  pc_raw = pc_plus;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   always_comb begin
      misalign_d = is_ext_target(sel) && (pc_raw[1:0] != 2'b00);
      pc_d       = is_ext_target(sel) ? (pc_raw & ~WIDTH'(3)) : pc_raw;
   end
`else
   assign pc_d = pc_raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_VEC;
         ras_hit_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ras_hit_q <= ras_hit_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end

   assign misalign = misalign_q;
`endif

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (link_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

endmodule
